// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
// N-approach traffic-light controller: sensor-driven round-robin service,
// min/max green with extension while a vehicle is present, a latched
// pedestrian walk phase, and a night flash mode.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   sensor      per-approach vehicle present (level)
//   ped_req     pedestrian request (pulse, latched internally)
//   flash_mode  night flash request (level)
//   light       per-approach code in [2i+1:2i]: 00 red, 01 green, 10 yellow, 11 dark
//   walk        pedestrian walk lamp
//   active_dir  approach currently or last served
module traffic_intersection_ctrl #(
    parameter int unsigned N_DIR     = 2,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 10,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned PED_T     = 3,
    parameter int unsigned FLASH_T   = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [N_DIR-1:0]                         sensor,
    input  logic                                     ped_req,
    input  logic                                     flash_mode,
    output logic [2*N_DIR-1:0]                       light,
    output logic                                     walk,
    output logic [((N_DIR > 1) ? $clog2(N_DIR) : 1)-1:0] active_dir
);

    localparam int unsigned DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;
    localparam int unsigned EL_W  = CNT_W + 1;
    localparam int          ND    = int'(N_DIR);

    localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(N_DIR - 1);

    localparam logic [1:0] L_RED    = 2'b00;
    localparam logic [1:0] L_GREEN  = 2'b01;
    localparam logic [1:0] L_YELLOW = 2'b10;
    localparam logic [1:0] L_DARK   = 2'b11;

    localparam logic [EL_W-1:0] EL_ALLRED = EL_W'(ALLRED_T);
    localparam logic [EL_W-1:0] EL_GMIN   = EL_W'(GREEN_MIN);
    localparam logic [EL_W-1:0] EL_GMAX   = EL_W'(GREEN_MAX);
    localparam logic [EL_W-1:0] EL_YELLOW = EL_W'(YELLOW_T);
    localparam logic [EL_W-1:0] EL_PED    = EL_W'(PED_T);
    localparam logic [EL_W-1:0] EL_FLASH  = EL_W'(FLASH_T);

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_WALK   = 3'd3,
        S_FLASH  = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   tmr, tmr_n, tmr_inc;
    logic [EL_W-1:0]    elapsed;
    logic [DIR_W-1:0]   dir_n, next_dir;
    logic               ped_pending, ped_n;
    logic               phase, phase_n;
    logic [2*N_DIR-1:0] light_n;
    logic               walk_n;
    logic               own_sensor, other_demand;

    // Saturating phase timer; elapsed counts the current cycle too
    always_comb begin
        tmr_inc = (tmr == {CNT_W{1'b1}}) ? tmr : tmr + CNT_W'(1);
        elapsed = {1'b0, tmr} + EL_W'(1);
    end

    // Demand classification and circular search for the next sensed approach
    always_comb begin
        int best_d;
        int d;
        own_sensor   = 1'b0;
        other_demand = ped_pending;
        next_dir     = DIR_W'((int'(active_dir) + 1) % ND);
        best_d       = ND + 1;
        d            = 0;
        for (int i = 0; i < ND; i++) begin
            // distance after active_dir; the active approach itself is last
            d = (i + ND - int'(active_dir)) % ND;
            if (d == 0) d = ND;
            if (sensor[i]) begin
                if (d == ND) own_sensor = 1'b1;
                else         other_demand = 1'b1;
                if (d < best_d) begin
                    best_d   = d;
                    next_dir = DIR_W'(i);
                end
            end
        end
    end

    // Next-state logic and output decode of the next state
    always_comb begin
        state_n = state;
        tmr_n   = tmr_inc;
        dir_n   = active_dir;
        ped_n   = ped_pending | (ped_req && (state != S_WALK));
        phase_n = phase;
        light_n = '0;
        walk_n  = 1'b0;

        case (state)
            S_ALLRED: begin
                if (elapsed >= EL_ALLRED) begin
                    tmr_n = '0;
                    if (flash_mode) begin
                        state_n = S_FLASH;
                        phase_n = 1'b0;
                    end else if (ped_pending) begin
                        state_n = S_WALK;
                        ped_n   = 1'b0;
                    end else begin
                        state_n = S_GREEN;
                        dir_n   = next_dir;
                    end
                end
            end
            S_GREEN: begin
                if ((elapsed >= EL_GMIN) &&
                    (flash_mode ||
                     (other_demand && (!own_sensor || (elapsed >= EL_GMAX))))) begin
                    state_n = S_YELLOW;
                    tmr_n   = '0;
                end
            end
            S_YELLOW: begin
                if (elapsed >= EL_YELLOW) begin
                    state_n = S_ALLRED;
                    tmr_n   = '0;
                end
            end
            S_WALK: begin
                if (elapsed >= EL_PED) begin
                    tmr_n = '0;
                    if (flash_mode) begin
                        state_n = S_FLASH;
                        phase_n = 1'b0;
                    end else begin
                        state_n = S_GREEN;
                        dir_n   = next_dir;
                    end
                end
            end
            S_FLASH: begin
                // flash_mode is only honoured at half-period boundaries
                if (elapsed >= EL_FLASH) begin
                    tmr_n = '0;
                    if (!flash_mode) begin
                        state_n = S_ALLRED;
                        phase_n = 1'b0;
                    end else begin
                        phase_n = ~phase;
                    end
                end
            end
            default: begin
                state_n = S_ALLRED;
                tmr_n   = '0;
            end
        endcase

        for (int i = 0; i < ND; i++) begin
            case (state_n)
                S_GREEN:  light_n[2*i +: 2] = (i == int'(dir_n)) ? L_GREEN : L_RED;
                S_YELLOW: light_n[2*i +: 2] = (i == int'(dir_n)) ? L_YELLOW : L_RED;
                S_FLASH:  light_n[2*i +: 2] = phase_n ? L_DARK : L_YELLOW;
                default:  light_n[2*i +: 2] = L_RED;
            endcase
        end
        walk_n = (state_n == S_WALK);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_ALLRED;
            tmr         <= '0;
            active_dir  <= LAST_DIR;
            ped_pending <= 1'b0;
            phase       <= 1'b0;
            light       <= '0;
            walk        <= 1'b0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            active_dir  <= dir_n;
            ped_pending <= ped_n;
            phase       <= phase_n;
            light       <= light_n;
            walk        <= walk_n;
        end
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl at default parameters.
module tb_traffic_intersection_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] sensor;
    logic       ped_req;
    logic       flash_mode;
    logic [3:0] light;
    logic       walk;
    logic [0:0] active_dir;

    int total;
    int bad;

    traffic_intersection_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .sensor     (sensor),
        .ped_req    (ped_req),
        .flash_mode (flash_mode),
        .light      (light),
        .walk       (walk),
        .active_dir (active_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] el, input logic ew, input logic ed);
        total++;
        assert (light === el && walk === ew && active_dir === ed)
        else begin
            bad++;
            $error("FAIL %s: got light=%b walk=%b dir=%b, expected light=%b walk=%b dir=%b",
                   tag, light, walk, active_dir, el, ew, ed);
        end
    endtask

    task automatic expect_n(input string tag, input int n, input logic [3:0] el,
                            input logic ew, input logic ed);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, el, ew, ed);
        end
    endtask

    // Reset, release, and observe the first green on dir 0
    task automatic do_reset();
        reset      = 1'b1;
        sensor     = 2'b00;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        tick();
        chk("rst_state", 4'b0000, 1'b0, 1'b1);
        reset = 1'b0;
        chk("rel_allred", 4'b0000, 1'b0, 1'b1);
        tick();
        chk("first_green", 4'b0001, 1'b0, 1'b0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        sensor     = 2'b00;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        tick();
        tick();

        // Idle: dir 0 green held with no demand
        do_reset();
        expect_n("idle_hold", 54, 4'b0001, 1'b0, 1'b0);

        // sensor=10: minimum green then hand over to dir 1
        do_reset();
        sensor = 2'b10;
        expect_n("min_green",  3, 4'b0001, 1'b0, 1'b0);
        expect_n("min_yellow", 2, 4'b0010, 1'b0, 1'b0);
        expect_n("min_allred", 1, 4'b0000, 1'b0, 1'b0);
        expect_n("min_next",   5, 4'b0100, 1'b0, 1'b1);

        // sensor=11: extension to maximum green
        do_reset();
        sensor = 2'b11;
        expect_n("max_green",  9, 4'b0001, 1'b0, 1'b0);
        expect_n("max_yellow", 2, 4'b0010, 1'b0, 1'b0);
        expect_n("max_allred", 1, 4'b0000, 1'b0, 1'b0);
        expect_n("max_next",   1, 4'b0100, 1'b0, 1'b1);

        // Pedestrian pulse during dir 0 green; second request in walk ignored
        do_reset();
        ped_req = 1'b1;
        tick();
        chk("ped_green", 4'b0001, 1'b0, 1'b0);
        ped_req = 1'b0;
        expect_n("ped_green",  2, 4'b0001, 1'b0, 1'b0);
        expect_n("ped_yellow", 2, 4'b0010, 1'b0, 1'b0);
        expect_n("ped_allred", 1, 4'b0000, 1'b0, 1'b0);
        expect_n("ped_walk",   1, 4'b0000, 1'b1, 1'b0);
        ped_req = 1'b1;
        tick();
        chk("ped_walk", 4'b0000, 1'b1, 1'b0);
        ped_req = 1'b0;
        expect_n("ped_walk",   1, 4'b0000, 1'b1, 1'b0);
        expect_n("ped_after",  20, 4'b0100, 1'b0, 1'b1);

        // Flash from dir 1 green, then drop flash mid dark half
        flash_mode = 1'b1;
        expect_n("fl_yellow", 2, 4'b1000, 1'b0, 1'b1);
        expect_n("fl_allred", 1, 4'b0000, 1'b0, 1'b1);
        expect_n("fl_on",     2, 4'b1010, 1'b0, 1'b1);
        expect_n("fl_off",    2, 4'b1111, 1'b0, 1'b1);
        expect_n("fl_on2",    2, 4'b1010, 1'b0, 1'b1);
        expect_n("fl_off2",   1, 4'b1111, 1'b0, 1'b1);
        flash_mode = 1'b0;
        expect_n("fl_off2",   1, 4'b1111, 1'b0, 1'b1);
        expect_n("fl_exit",   1, 4'b0000, 1'b0, 1'b1);
        expect_n("fl_green",  1, 4'b0001, 1'b0, 1'b0);

        // Reset mid-yellow with a pending pedestrian request
        ped_req = 1'b1;
        tick();
        chk("rm_green", 4'b0001, 1'b0, 1'b0);
        ped_req = 1'b0;
        expect_n("rm_green",  2, 4'b0001, 1'b0, 1'b0);
        expect_n("rm_yellow", 1, 4'b0010, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_async", 4'b0000, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        chk("rm_rel", 4'b0000, 1'b0, 1'b1);
        tick();
        chk("rm_green0", 4'b0001, 1'b0, 1'b0);
        expect_n("rm_nowalk", 10, 4'b0001, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
